// File: rtl/wb_cfg_loader.sv
// Wishbone slave that buffers CPU-written configuration words in a small FIFO and
// shifts them LSB-first into the eFPGA configuration chain with a generated prog_clk.
//
// state    | meaning
// IDLE     | waiting for START
// LOAD     | finish if the bit count is reached, else pop the next word
// SHIFT_LO | prog_clk low, ccff_head carries the next bit
// SHIFT_HI | prog_clk high, chain captures the bit
// DONE     | bitstream complete, cfg_done high
module wb_cfg_loader #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          CNT_W      = 20
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        prog_clk_o,
  output logic        ccff_head_o,
  input  logic        ccff_tail_i,
  output logic        prog_reset_o,
  output logic        cfg_done_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT_LO, S_SHIFT_HI, S_DONE} state_t;
  state_t state;

  logic [31:0]      fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [AW:0]      fifo_cnt;
  logic             fifo_empty, fifo_full;
  logic             start_pend, abort_pend, tail_q;
  logic [CNT_W-1:0] bitcnt, n_bits, bits_shifted;
  logic [31:0]      sr;
  logic [4:0]       bit_left;
  logic             hit, data_wr, push, pop, accept, busy;
  logic [1:0]       reg_sel;
  logic [31:0]      status, rdata;
  logic             unused_bits;

  assign unused_bits = ^{wbs_sel_i, wbs_adr_i[1:0]};
  assign fifo_empty  = (fifo_cnt == '0);
  assign fifo_full   = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
  assign busy        = (state == S_LOAD) || (state == S_SHIFT_LO) || (state == S_SHIFT_HI);
  assign reg_sel     = wbs_adr_i[3:2];

  // Gating with the current ack keeps two acks from ever landing back to back.
  assign hit     = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign data_wr = hit & wbs_we_i & (reg_sel == 2'd2);
  assign pop     = (state == S_LOAD) & ~abort_pend & ~fifo_empty & (bits_shifted != n_bits);
  assign push    = data_wr & (~fifo_full | pop);
  assign accept  = hit & ~(data_wr & ~push);

  always_comb begin
    status = '0;
    status[0] = busy;
    status[1] = cfg_done_o;
    status[2] = fifo_empty;
    status[3] = fifo_full;
    status[4] = tail_q;
    status[8 +: CNT_W] = bits_shifted;
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      2'd0:    rdata[1] = prog_reset_o;
      2'd1:    rdata = status;
      2'd3:    rdata[CNT_W-1:0] = bitcnt;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs_ack_o    <= 1'b0;
      wbs_dat_o    <= '0;
      prog_reset_o <= 1'b0;
      bitcnt       <= '0;
      start_pend   <= 1'b0;
      abort_pend   <= 1'b0;
    end else begin
      wbs_ack_o  <= accept;
      wbs_dat_o  <= (accept & ~wbs_we_i) ? rdata : '0;
      start_pend <= 1'b0;
      abort_pend <= 1'b0;
      if (accept & wbs_we_i) begin
        if (reg_sel == 2'd0) begin
          prog_reset_o <= wbs_dat_i[1];
          start_pend   <= wbs_dat_i[0];
          abort_pend   <= wbs_dat_i[2];
        end
        if (reg_sel == 2'd3) bitcnt <= wbs_dat_i[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) fifo_mem[abort_pend ? '0 : wr_ptr] <= wbs_dat_i;
  end

  // A push landing on the flush cycle becomes the only word left in the FIFO.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (abort_pend) begin
      rd_ptr   <= '0;
      wr_ptr   <= push ? AW'(1) : '0;
      fifo_cnt <= push ? (AW+1)'(1) : '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state        <= S_IDLE;
      sr           <= '0;
      bit_left     <= '0;
      bits_shifted <= '0;
      n_bits       <= '0;
      tail_q       <= 1'b0;
      prog_clk_o   <= 1'b0;
      ccff_head_o  <= 1'b0;
      cfg_done_o   <= 1'b0;
    end else if (abort_pend) begin
      state      <= S_IDLE;
      prog_clk_o <= 1'b0;
      cfg_done_o <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_pend) begin
            n_bits <= bitcnt;
            if (bitcnt == '0) begin
              state      <= S_DONE;
              cfg_done_o <= 1'b1;
            end else begin
              state        <= S_LOAD;
              bits_shifted <= '0;
              cfg_done_o   <= 1'b0;
            end
          end
        end
        S_LOAD: begin
          if (bits_shifted == n_bits) begin
            state      <= S_DONE;
            cfg_done_o <= 1'b1;
          end else if (pop) begin
            sr          <= fifo_mem[rd_ptr];
            ccff_head_o <= fifo_mem[rd_ptr][0];
            bit_left    <= 5'd31;
            state       <= S_SHIFT_LO;
          end
        end
        S_SHIFT_LO: begin
          prog_clk_o <= 1'b1;
          tail_q     <= ccff_tail_i;
          state      <= S_SHIFT_HI;
        end
        S_SHIFT_HI: begin
          prog_clk_o   <= 1'b0;
          sr           <= sr >> 1;
          bits_shifted <= bits_shifted + CNT_W'(1);
          bit_left     <= bit_left - 5'd1;
          if ((bits_shifted + CNT_W'(1) == n_bits) || (bit_left == 5'd0)) begin
            state <= S_LOAD;
          end else begin
            ccff_head_o <= sr[1];
            state       <= S_SHIFT_LO;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cfg_loader.sv
// Bench for wb_cfg_loader: drives Wishbone transfers, logs every prog_clk rise and
// compares the shifted stream and status against a word/bit-index reference model.
module tb_wb_cfg_loader;

  localparam int CNT_W = 20;
  localparam logic [31:0] A_CTRL = 32'h3000_0000;
  localparam logic [31:0] A_STAT = 32'h3000_0004;
  localparam logic [31:0] A_DATA = 32'h3000_0008;
  localparam logic [31:0] A_BCNT = 32'h3000_000C;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack;
  logic [31:0] dat_o;
  logic        prog_clk, ccff_head, ccff_tail, prog_reset, cfg_done;
  logic        loopback = 1'b0;

  always #5 clk = ~clk;

  assign ccff_tail = loopback ? ccff_head : 1'b0;

  wb_cfg_loader #(.BASE_ADDR(32'h3000_0000), .FIFO_DEPTH(4), .CNT_W(CNT_W)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .prog_clk_o(prog_clk), .ccff_head_o(ccff_head), .ccff_tail_i(ccff_tail),
    .prog_reset_o(prog_reset), .cfg_done_o(cfg_done)
  );

  int n_vec = 0;
  int n_err = 0;

  // Monitor on the falling edge: cycle count, prog_clk rises, done rise.
  int   cyc_n = 0;
  int   pulse_cnt = 0;
  int   done_rise = 0;
  logic pclk_q = 1'b0, done_q = 1'b0;
  logic head_log [0:4095];
  int   rise_log [0:4095];

  always @(negedge clk) begin
    cyc_n  <= cyc_n + 1;
    pclk_q <= prog_clk;
    done_q <= cfg_done;
    if (prog_clk && !pclk_q) begin
      head_log[pulse_cnt] <= ccff_head;
      rise_log[pulse_cnt] <= cyc_n + 1;
      pulse_cnt <= pulse_cnt + 1;
    end
    if (cfg_done && !done_q) done_rise <= cyc_n + 1;
  end

  // Reference model: bit k of the stream is bit (k mod 32) of word k/32.
  logic [31:0] words [0:7];

  function automatic logic exp_bit(input int k);
    logic [31:0] w;
    w = words[k / 32];
    return w[k % 32];
  endfunction

  task automatic wb_xfer(input logic w_en, input logic [31:0] a, input logic [31:0] d,
                         input int max_cyc, input logic must_ack,
                         output logic [31:0] rd, output logic ok, output int ack_cyc);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w_en; adr = a; wdat = d;
    ok = 1'b0; rd = '0; ack_cyc = 0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(posedge clk); #1;
      if (ack) begin ok = 1'b1; rd = dat_o; ack_cyc = cyc_n; end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    if (must_ack && !ok) begin
      n_err++;
      $display("FAIL bus_timeout adr=%08h got no ack want ack within %0d cycles", a, max_cyc);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r; logic ok; int c;
    wb_xfer(1'b1, a, d, 20, 1'b1, r, ok, c);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] r);
    logic ok; int c;
    wb_xfer(1'b0, a, 32'h0, 20, 1'b1, r, ok, c);
  endtask

  task automatic run_prog(input int n, input int nw, output int base, output int st_cyc,
                          output logic fin);
    logic [31:0] r; logic ok;
    base = pulse_cnt;
    wr(A_BCNT, 32'(n));
    for (int i = 0; i < nw; i++) wr(A_DATA, words[i]);
    wb_xfer(1'b1, A_CTRL, 32'h1, 20, 1'b1, r, ok, st_cyc);
    fin = 1'b0;
    for (int i = 0; i < 80 * nw + 40 && !fin; i++) begin
      @(posedge clk); #1;
      if (cfg_done) fin = 1'b1;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    wr(A_CTRL, 32'h2);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({ack, dat_o, prog_clk, ccff_head, prog_reset, cfg_done} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got ack=%0b dat=%08h pclk=%0b head=%0b prst=%0b done=%0b want all 0",
               ack, dat_o, prog_clk, ccff_head, prog_reset, cfg_done);
    end
    @(negedge clk); rst_n = 1'b1;
    rd(A_STAT, r);
    n_vec++;
    if (r !== 32'h0000_0004) begin n_err++; $display("FAIL reset_status got %08h want 00000004", r); end
    rd(A_BCNT, r);
    n_vec++;
    if (r !== 32'h0) begin n_err++; $display("FAIL reset_bitcnt got %08h want 00000000", r); end
  endtask

  task automatic test_prog_rst();
    logic [31:0] r;
    wr(A_CTRL, 32'h2);
    n_vec++;
    if (prog_reset !== 1'b1) begin n_err++; $display("FAIL prog_rst_set got %0b want 1", prog_reset); end
    @(posedge clk); #1;
    n_vec++;
    if (ack !== 1'b0) begin n_err++; $display("FAIL ack_single_cycle got %0b want 0", ack); end
    rd(A_CTRL, r);
    n_vec++;
    if (r !== 32'h2) begin n_err++; $display("FAIL ctrl_read got %08h want 00000002", r); end
    @(posedge clk); #1;
    n_vec++;
    if (dat_o !== 32'h0) begin n_err++; $display("FAIL dat_idle_zero got %08h want 00000000", dat_o); end
    wr(A_CTRL, 32'h0);
    n_vec++;
    if (prog_reset !== 1'b0) begin n_err++; $display("FAIL prog_rst_clr got %0b want 0", prog_reset); end
    rd(A_DATA, r);
    n_vec++;
    if (r !== 32'h0) begin n_err++; $display("FAIL data_read got %08h want 00000000", r); end
  endtask

  task automatic test_single_word();
    int base, st; logic fin; logic [31:0] r;
    words[0] = 32'hA5A5_0001;
    run_prog(32, 1, base, st, fin);
    n_vec++;
    if (!fin) begin n_err++; $display("FAIL single_done_timeout got 0 want 1"); end
    n_vec++;
    if (pulse_cnt - base != 32) begin n_err++; $display("FAIL single_pulses got %0d want 32", pulse_cnt - base); end
    for (int k = 0; k < 32; k++) begin
      n_vec++;
      if (head_log[base + k] !== exp_bit(k)) begin
        n_err++; $display("FAIL single_bit[%0d] got %0b want %0b", k, head_log[base + k], exp_bit(k));
      end
    end
    n_vec++;
    if (rise_log[base] - st != 4) begin n_err++; $display("FAIL start_latency got %0d want 4", rise_log[base] - st); end
    n_vec++;
    if (rise_log[base + 1] - rise_log[base] != 2) begin
      n_err++; $display("FAIL prog_clk_period got %0d want 2", rise_log[base + 1] - rise_log[base]);
    end
    n_vec++;
    if (done_rise - rise_log[base + 31] != 2) begin
      n_err++; $display("FAIL done_latency got %0d want 2", done_rise - rise_log[base + 31]);
    end
    rd(A_STAT, r);
    n_vec++;
    if (r !== 32'h0000_2006) begin n_err++; $display("FAIL single_status got %08h want 00002006", r); end
  endtask

  task automatic test_partial_word();
    int base, st; logic fin;
    words[0] = 32'hFFFF_FFFF;
    words[1] = 32'h0000_00F0;
    run_prog(40, 2, base, st, fin);
    repeat (20) @(posedge clk);
    #1;
    n_vec++;
    if (!fin) begin n_err++; $display("FAIL partial_done_timeout got 0 want 1"); end
    n_vec++;
    if (pulse_cnt - base != 40) begin n_err++; $display("FAIL partial_pulses got %0d want 40", pulse_cnt - base); end
    for (int k = 0; k < 40; k++) begin
      n_vec++;
      if (head_log[base + k] !== exp_bit(k)) begin
        n_err++; $display("FAIL partial_bit[%0d] got %0b want %0b", k, head_log[base + k], exp_bit(k));
      end
    end
    n_vec++;
    if (rise_log[base + 32] - rise_log[base + 31] != 3) begin
      n_err++; $display("FAIL word_boundary_gap got %0d want 3", rise_log[base + 32] - rise_log[base + 31]);
    end
  endtask

  task automatic test_zero_count();
    logic [31:0] r; logic ok; int st, base;
    wr(A_CTRL, 32'h4);
    @(posedge clk); #1;
    n_vec++;
    if (cfg_done !== 1'b0) begin n_err++; $display("FAIL abort_clears_done got %0b want 0", cfg_done); end
    base = pulse_cnt;
    wr(A_BCNT, 32'h0);
    wb_xfer(1'b1, A_CTRL, 32'h1, 20, 1'b1, r, ok, st);
    repeat (6) @(posedge clk);
    #1;
    n_vec++;
    if (cfg_done !== 1'b1) begin n_err++; $display("FAIL zero_done got %0b want 1", cfg_done); end
    n_vec++;
    if (done_rise - st != 2) begin n_err++; $display("FAIL zero_done_latency got %0d want 2", done_rise - st); end
    n_vec++;
    if (pulse_cnt != base) begin n_err++; $display("FAIL zero_pulses got %0d want 0", pulse_cnt - base); end
  endtask

  task automatic test_back_pressure();
    logic [31:0] r; logic ok; int st, a5, base; logic fin;
    for (int i = 0; i < 5; i++) words[i] = $urandom();
    wr(A_BCNT, 32'h0);
    for (int i = 0; i < 4; i++) wr(A_DATA, words[i]);
    wb_xfer(1'b1, A_DATA, words[4], 8, 1'b0, r, ok, a5);
    n_vec++;
    if (ok !== 1'b0) begin n_err++; $display("FAIL full_stall got ack=%0b want 0", ok); end
    rd(A_STAT, r);
    n_vec++;
    if (r[3:2] !== 2'b10) begin n_err++; $display("FAIL full_status got full/empty=%02b want 10", r[3:2]); end
    base = pulse_cnt;
    wr(A_BCNT, 32'd160);
    wb_xfer(1'b1, A_CTRL, 32'h1, 20, 1'b1, r, ok, st);
    wb_xfer(1'b1, A_DATA, words[4], 20, 1'b1, r, ok, a5);
    n_vec++;
    if (a5 - st != 2) begin n_err++; $display("FAIL stalled_ack_timing got %0d want 2", a5 - st); end
    fin = 1'b0;
    for (int i = 0; i < 500 && !fin; i++) begin
      @(posedge clk); #1;
      if (cfg_done) fin = 1'b1;
    end
    repeat (4) @(posedge clk);
    #1;
    n_vec++;
    if (!fin) begin n_err++; $display("FAIL bp_done_timeout got 0 want 1"); end
    n_vec++;
    if (pulse_cnt - base != 160) begin n_err++; $display("FAIL bp_pulses got %0d want 160", pulse_cnt - base); end
    for (int k = 0; k < 160; k++) begin
      n_vec++;
      if (head_log[base + k] !== exp_bit(k)) begin
        n_err++; $display("FAIL bp_bit[%0d] got %0b want %0b", k, head_log[base + k], exp_bit(k));
      end
    end
  endtask

  task automatic test_abort();
    logic [31:0] r; logic ok; int st, base, hi_cnt, k;
    words[0] = $urandom();
    words[1] = $urandom();
    base = pulse_cnt;
    wr(A_BCNT, 32'd64);
    wr(A_DATA, words[0]);
    wr(A_DATA, words[1]);
    wb_xfer(1'b1, A_CTRL, 32'h1, 20, 1'b1, r, ok, st);
    k = 0;
    for (int i = 0; i < 200 && k < 10; i++) begin
      @(posedge clk); #1;
      if (prog_clk) k++;
    end
    n_vec++;
    if (k != 10) begin n_err++; $display("FAIL abort_wait got %0d pulses want 10", k); end
    wr(A_CTRL, 32'h4);
    hi_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (prog_clk) hi_cnt++;
    end
    n_vec++;
    if (hi_cnt != 0) begin n_err++; $display("FAIL abort_pclk_low got %0d high cycles want 0", hi_cnt); end
    n_vec++;
    if (pulse_cnt - base != 10) begin n_err++; $display("FAIL abort_pulses got %0d want 10", pulse_cnt - base); end
    for (int j = 0; j < 10; j++) begin
      n_vec++;
      if (head_log[base + j] !== exp_bit(j)) begin
        n_err++; $display("FAIL abort_bit[%0d] got %0b want %0b", j, head_log[base + j], exp_bit(j));
      end
    end
    rd(A_STAT, r);
    n_vec++;
    if (r !== 32'h0000_0A04) begin n_err++; $display("FAIL abort_status got %08h want 00000a04", r); end
    n_vec++;
    if (cfg_done !== 1'b0) begin n_err++; $display("FAIL abort_done got %0b want 0", cfg_done); end
  endtask

  task automatic test_random();
    int n, nw, base, st; logic fin; logic [31:0] r, want;
    for (int it = 0; it < 4; it++) begin
      n  = $urandom_range(1, 128);
      nw = (n + 31) / 32;
      for (int i = 0; i < nw; i++) words[i] = $urandom();
      run_prog(n, nw, base, st, fin);
      n_vec++;
      if (!fin) begin n_err++; $display("FAIL rand%0d_done_timeout got 0 want 1", it); end
      n_vec++;
      if (pulse_cnt - base != n) begin
        n_err++; $display("FAIL rand%0d_pulses got %0d want %0d", it, pulse_cnt - base, n);
      end
      for (int k = 0; k < n; k++) begin
        n_vec++;
        if (head_log[base + k] !== exp_bit(k)) begin
          n_err++; $display("FAIL rand%0d_bit[%0d] got %0b want %0b", it, k, head_log[base + k], exp_bit(k));
        end
      end
      want = (32'(n) << 8) | 32'h6;
      rd(A_STAT, r);
      n_vec++;
      if (r !== want) begin n_err++; $display("FAIL rand%0d_status got %08h want %08h", it, r, want); end
    end
  endtask

  task automatic test_loopback();
    int base, st; logic fin; logic [31:0] r, want;
    words[0] = $urandom();
    words[1] = $urandom();
    loopback = 1'b1;
    run_prog(37, 2, base, st, fin);
    n_vec++;
    if (!fin) begin n_err++; $display("FAIL loop_done_timeout got 0 want 1"); end
    want = (32'd37 << 8) | 32'h6 | (32'(exp_bit(36)) << 4);
    rd(A_STAT, r);
    n_vec++;
    if (r !== want) begin n_err++; $display("FAIL loop_status got %08h want %08h", r, want); end
    loopback = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; logic ok; int st;
    words[0] = 32'hFFFF_FFFF;
    wr(A_CTRL, 32'h2);
    wr(A_BCNT, 32'd64);
    wr(A_DATA, words[0]);
    wr(A_DATA, words[0]);
    wb_xfer(1'b1, A_CTRL, 32'h3, 20, 1'b1, r, ok, st);
    repeat (20) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({ack, dat_o, prog_clk, ccff_head, prog_reset, cfg_done} !== '0) begin
      n_err++;
      $display("FAIL midreset_outputs got ack=%0b dat=%08h pclk=%0b head=%0b prst=%0b done=%0b want all 0",
               ack, dat_o, prog_clk, ccff_head, prog_reset, cfg_done);
    end
    @(negedge clk); rst_n = 1'b1;
    rd(A_STAT, r);
    n_vec++;
    if (r !== 32'h0000_0004) begin n_err++; $display("FAIL midreset_status got %08h want 00000004", r); end
    rd(A_BCNT, r);
    n_vec++;
    if (r !== 32'h0) begin n_err++; $display("FAIL midreset_bitcnt got %08h want 00000000", r); end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    test_reset();
    test_prog_rst();
    test_single_word();
    test_partial_word();
    test_zero_count();
    test_back_pressure();
    test_abort();
    test_random();
    test_loopback();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got simulation still running want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
